// File: rtl/vhd_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | vhd_responder: byte-stream virtual-disk responder (header, write, read). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module vhd_responder #(
  parameter int unsigned SECTOR_BYTES = 512,
  parameter int unsigned REPLY_GAP    = 16,
  parameter int unsigned RX_TIMEOUT   = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_start,
  input  logic        i_tx_busy,
  output logic [31:0] o_store_addr,
  output logic [7:0]  o_store_wdata,
  output logic        o_store_we,
  input  logic [7:0]  i_store_rdata,
  output logic        o_busy,
  output logic        o_err,
  output logic [15:0] o_frames_done
);

  localparam int unsigned    IDXW       = $clog2(SECTOR_BYTES) + 1;
  localparam logic [IDXW-1:0] c_LAST_IDX = IDXW'(SECTOR_BYTES - 1);
  localparam logic [31:0]    c_TMO_LAST = (RX_TIMEOUT > 0) ? 32'(RX_TIMEOUT - 1) : 32'd0;
  localparam logic [31:0]    c_GAP_LAST = (REPLY_GAP > 0) ? 32'(REPLY_GAP - 1) : 32'd0;

  localparam logic [7:0] c_CMD_READ  = 8'h01;
  localparam logic [7:0] c_CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_CMD     = 3'd2,
    S_WR_DATA = 3'd3,
    S_GAP     = 3'd4,
    S_RD_DATA = 3'd5
  } state_t;

  state_t            r_state;
  // Only offset[22:0] contributes to the sector base, so the top 9 bits are never stored.
  logic [22:0]       r_offset;
  logic [2:0]        r_byte_cnt;
  logic [IDXW-1:0]   r_idx;
  logic [31:0]       r_timer;
  logic [31:0]       r_gap;
  logic              r_outstanding;
  logic              r_busy_q;
  logic [15:0]       r_frames;
  logic [7:0]        r_tx_data;
  logic              r_tx_start;
  logic [31:0]       r_store_addr;
  logic [7:0]        r_store_wdata;
  logic              r_store_we;
  logic              r_err;

  logic [31:0]       w_base;
  logic [31:0]       w_idx_ext;
  logic [31:0]       w_addr_cur;
  logic [31:0]       w_addr_next;
  logic              w_rx_phase;
  logic              w_timeout;
  logic              w_tx_fall;
  logic              w_last_idx;

  assign w_base      = {r_offset, 9'b0};
  assign w_idx_ext   = {{(32-IDXW){1'b0}}, r_idx};
  assign w_addr_cur  = w_base + w_idx_ext;
  assign w_addr_next = w_addr_cur + 32'd1;
  assign w_rx_phase  = (r_state == S_HDR) || (r_state == S_CMD) || (r_state == S_WR_DATA);
  assign w_timeout   = w_rx_phase && !i_rx_valid && (r_timer == c_TMO_LAST);
  assign w_tx_fall   = r_busy_q && !i_tx_busy;
  assign w_last_idx  = (r_idx == c_LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_offset      <= '0;
      r_byte_cnt    <= '0;
      r_idx         <= '0;
      r_timer       <= '0;
      r_gap         <= '0;
      r_outstanding <= 1'b0;
      r_busy_q      <= 1'b0;
      r_frames      <= '0;
      r_tx_data     <= '0;
      r_tx_start    <= 1'b0;
      r_store_addr  <= '0;
      r_store_wdata <= '0;
      r_store_we    <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_store_we <= 1'b0;
      r_tx_start <= 1'b0;
      r_err      <= 1'b0;
      r_busy_q   <= i_tx_busy;

      // Inter-byte timer only runs while a frame is still arriving on rx.
      if (w_rx_phase && !i_rx_valid) begin
        r_timer <= r_timer + 32'd1;
      end else begin
        r_timer <= '0;
      end

      case (r_state)
        S_IDLE: begin
          if (i_rx_valid) begin
            r_offset   <= '0;
            r_byte_cnt <= 3'd1;
            r_state    <= S_HDR;
          end
        end

        S_HDR: begin
          if (i_rx_valid) begin
            case (r_byte_cnt)
              3'd1:    r_offset[22:16] <= i_rx_data[6:0];
              3'd2:    r_offset[15:8]  <= i_rx_data;
              3'd3:    r_offset[7:0]   <= i_rx_data;
              default: r_offset        <= r_offset;
            endcase
            r_byte_cnt <= r_byte_cnt + 3'd1;
            if (r_byte_cnt == 3'd3) begin
              r_state <= S_CMD;
            end
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end
        end

        S_CMD: begin
          if (i_rx_valid) begin
            r_idx <= '0;
            r_gap <= '0;
            if (i_rx_data == c_CMD_WRITE) begin
              r_state <= S_WR_DATA;
            end else if (i_rx_data == c_CMD_READ) begin
              r_state <= S_GAP;
            end else begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
            end
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end
        end

        S_WR_DATA: begin
          if (i_rx_valid) begin
            r_store_addr  <= w_addr_cur;
            r_store_wdata <= i_rx_data;
            r_store_we    <= 1'b1;
            if (w_last_idx) begin
              r_idx    <= '0;
              r_frames <= r_frames + 16'd1;
              r_state  <= S_IDLE;
            end else begin
              r_idx <= r_idx + IDXW'(1);
            end
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end
        end

        S_GAP: begin
          if (r_gap == c_GAP_LAST) begin
            r_idx         <= '0;
            r_store_addr  <= w_base;
            r_outstanding <= 1'b0;
            r_state       <= S_RD_DATA;
          end else begin
            r_gap <= r_gap + 32'd1;
          end
        end

        S_RD_DATA: begin
          // The address is advanced on the falling edge so it is already
          // settled when the next byte is launched.
          if (r_outstanding && w_tx_fall) begin
            r_outstanding <= 1'b0;
            if (w_last_idx) begin
              r_idx    <= '0;
              r_frames <= r_frames + 16'd1;
              r_state  <= S_IDLE;
            end else begin
              r_idx        <= r_idx + IDXW'(1);
              r_store_addr <= w_addr_next;
            end
          end else if (!r_outstanding && !i_tx_busy) begin
            r_tx_data     <= i_store_rdata;
            r_tx_start    <= 1'b1;
            r_outstanding <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_tx_data     = r_tx_data;
  assign o_tx_start    = r_tx_start;
  assign o_store_addr  = r_store_addr;
  assign o_store_wdata = r_store_wdata;
  assign o_store_we    = r_store_we;
  assign o_busy        = (r_state != S_IDLE);
  assign o_err         = r_err;
  assign o_frames_done = r_frames;

endmodule
`default_nettype wire

// File: doc/vhd_responder.md
VHD_RESPONDER -- requirements
Module: vhd_responder

Interface
REQ-001 Parameter SECTOR_BYTES, default 512: bytes per data phase.
REQ-002 Parameter REPLY_GAP, default 16: idle cycles between the command byte and the first read-reply byte.
REQ-003 Parameter RX_TIMEOUT, default 100000: maximum cycles allowed between consecutive rx bytes inside a frame.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 rx_data  in  8  received byte; valid only while rx_valid=1.
REQ-007 rx_valid  in  1  one-cycle strobe per received byte.
REQ-008 tx_data  out  8  byte to transmit.
REQ-009 tx_start  out  1  one-cycle start strobe to the transmitter.
REQ-010 tx_busy  in  1  transmitter busy.
REQ-011 store_addr  out  32  backing-store byte address.
REQ-012 store_wdata  out  8  backing-store write byte.
REQ-013 store_we  out  1  backing-store write enable, one cycle per byte.
REQ-014 store_rdata  in  8  backing-store read byte, combinational from store_addr.
REQ-015 busy  out  1  high whenever state is not IDLE.
REQ-016 err  out  1  one-cycle pulse on a protocol error.
REQ-017 frames_done  out  16  count of completed frames.

Function
REQ-018 Frame format: offset[31:24], offset[23:16], offset[15:8], offset[7:0], command byte; cmd 8'h02 = host write (SECTOR_BYTES bytes follow on rx); cmd 8'h01 = host read (responder sends SECTOR_BYTES bytes on tx).
REQ-019 States: IDLE, HDR, CMD, WR_DATA, GAP, RD_DATA.
REQ-020 IDLE: on rx_valid, latch byte into offset[31:24], byte_cnt<=1, go to HDR.
REQ-021 HDR: each rx_valid shifts the byte into the next lower offset byte; after the 4th offset byte, go to CMD.
REQ-022 CMD: on rx_valid, cmd 02 -> WR_DATA; cmd 01 -> GAP; any other value -> err pulse, IDLE, no store access.
REQ-023 Sector base address = {offset[22:0], 9'b0}; offset[31:23] is ignored.
REQ-024 WR_DATA: each rx_valid drives store_addr = base + idx, store_wdata = rx_data, store_we = 1 for exactly that cycle, idx+1; after byte SECTOR_BYTES-1 is written: frames_done+1, IDLE.
REQ-025 GAP: count REPLY_GAP cycles, then go to RD_DATA with idx=0.
REQ-026 RD_DATA: store_addr = base + idx continuously; when tx_busy=0 and no byte is outstanding, tx_data <= store_rdata, tx_start=1 for one cycle, mark the byte outstanding.
REQ-027 The outstanding mark clears on a tx_busy falling edge (registered previous value 1, current 0); idx increments at the same time.
REQ-028 After the falling edge of byte SECTOR_BYTES-1: frames_done+1, IDLE; no tx_start is issued after the last byte.
REQ-029 A tx_start asserted while tx_busy is already high is forbidden.
REQ-030 Timeout: in HDR, CMD or WR_DATA, RX_TIMEOUT cycles without rx_valid -> err pulse, IDLE; any bytes already stored are kept; the counter restarts on every rx_valid.
REQ-031 rx_valid is ignored in GAP and RD_DATA (half-duplex); bytes received there are dropped.
REQ-032 frames_done wraps from 16'hFFFF to 0.
REQ-033 idx width is ceil(log2(SECTOR_BYTES))+1; store_addr arithmetic is 32-bit modulo 2^32.
REQ-034 store_we and tx_start are never high in the same cycle.

Reset
REQ-035 rst=1 at a clock edge -> state IDLE; offset, idx, byte_cnt, timers, outstanding flag and frames_done = 0.
REQ-036 Reset values of outputs: tx_data=0, tx_start=0, store_addr=0, store_wdata=0, store_we=0, busy=0, err=0.
REQ-037 Reset mid-frame aborts the frame with no err pulse and no further store or tx activity; the previous tx_busy register also resets to 0.

Verification
REQ-038 Send 00 00 00 03, 02, then bytes 0..511 mod 256 -> 512 store_we pulses, addresses 0x600..0x7FF, data equal to the sent bytes, frames_done=1.
REQ-039 Send 00 00 00 03, 01 with store preloaded to pattern addr[7:0]^8'hA5 -> after REPLY_GAP cycles, 512 tx bytes equal to the pattern, each tx_start only when tx_busy=0, frames_done=2.
REQ-040 Send 00 00 00 00, 07 -> one err pulse, busy low next cycle, no store_we, no tx_start.
REQ-041 Send 3 header bytes then silence for RX_TIMEOUT cycles -> err pulse, IDLE; a following valid frame completes normally.
REQ-042 Assert rst during WR_DATA after 100 bytes -> store_we stops immediately, busy=0, frames_done=0, no err pulse.
REQ-043 Send offset FF FF FF FF, cmd 02 -> addresses 0xFFFFFE00..0xFFFFFFFF, with offset[31:23] dropped.
